// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: word width, the canonical NOP,
// the halt sentinel instruction and the fetch FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // All-zero word is an illegal encoding; fetching it parks the front end.
    localparam logic [XLEN-1:0] INST_HALT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority is flush > hold > load; flushing
// injects a NOP bubble with a zeroed PC pair and valid cleared.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            pc4_d   = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!hold_i && load_i) begin
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to build the fetch/flush performance counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_inst_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o,
    output logic [XLEN-1:0] ifid_inst_o,
    output logic            ifid_valid_o,
    output logic            halted_o,
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] flush_cnt_o
);

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~32'h3;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_load, ifid_flush, ifid_hold;

    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b1;
        if (redirect_i) begin
            pc_d       = redirect_pc_i & PC_ALIGN_MASK;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall_i) begin
                        if (imem_inst_i == INST_HALT) begin
                            // Park on the sentinel; PC stays on it for debug.
                            ifid_flush = 1'b1;
                            state_d    = HALT;
                        end else begin
                            pc_d      = pc_plus4;
                            ifid_load = 1'b1;
                            ifid_hold = 1'b0;
                        end
                    end
                end
                HALT: begin
                    // stall_i is irrelevant here; only redirect or reset leave.
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .hold_i  (ifid_hold),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .inst_i  (imem_inst_i),
        .pc_o    (ifid_pc_o),
        .pc4_o   (ifid_pc4_o),
        .inst_o  (ifid_inst_o),
        .valid_o (ifid_valid_o)
    );

    assign imem_addr_o = pc_q;
    assign halted_o    = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (ifid_load ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (redirect_i ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign fetch_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes the expected
// post-edge state per cycle; the sampled DUT outputs are popped and compared.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] inst;
        logic        valid;
        logic        halted;
        logic [31:0] fcnt;
        logic [31:0] flcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_inst;
    logic [31:0] ifid_pc, ifid_pc4, ifid_inst;
    logic        ifid_valid, halted;
    logic [31:0] fetch_cnt, flush_cnt;
    logic [31:0] halt_addr;

    logic        zero_bit  = 1'b0;
    logic [31:0] zero_word = 32'h0;
    logic [31:0] imem_addr2, imem_inst2;
    logic [31:0] ifid_pc2, ifid_pc42, ifid_inst2;
    logic        ifid_valid2, halted2;
    logic [31:0] fetch_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_inst, m_fcnt, m_flcnt;
    logic        m_valid, m_halt;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_at(input logic [31:0] a, input logic [31:0] ha);
        if (a == ha) return 32'h0;
        if (a == 32'h0) return 32'h0000_0B13;
        if (a == 32'h4) return 32'h0000_0B93;
        return {a[23:0], 8'h13};
    endfunction

    assign imem_inst  = inst_at(imem_addr, halt_addr);
    assign imem_inst2 = inst_at(imem_addr2, 32'h1);

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_inst_i   (imem_inst),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_inst_o   (ifid_inst),
        .ifid_valid_o  (ifid_valid),
        .halted_o      (halted),
        .fetch_cnt_o   (fetch_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (zero_bit),
        .redirect_i    (zero_bit),
        .redirect_pc_i (zero_word),
        .imem_addr_o   (imem_addr2),
        .imem_inst_i   (imem_inst2),
        .ifid_pc_o     (ifid_pc2),
        .ifid_pc4_o    (ifid_pc42),
        .ifid_inst_o   (ifid_inst2),
        .ifid_valid_o  (ifid_valid2),
        .halted_o      (halted2),
        .fetch_cnt_o   (fetch_cnt2),
        .flush_cnt_o   (flush_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_inst = NOP;
        m_valid = 1'b0; m_halt = 1'b0; m_fcnt = 32'h0; m_flcnt = 32'h0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},   imem_addr, 32'h0);
        check({tag, "_ifpc"},   ifid_pc, 32'h0);
        check({tag, "_ifpc4"},  ifid_pc4, 32'h0);
        check({tag, "_inst"},   ifid_inst, NOP);
        check({tag, "_valid"},  {31'b0, ifid_valid}, 32'h0);
        check({tag, "_halted"}, {31'b0, halted}, 32'h0);
        check({tag, "_fcnt"},   fetch_cnt, 32'h0);
        check({tag, "_flcnt"},  flush_cnt, 32'h0);
    endtask

    task automatic cycle(input bit s, input bit r, input logic [31:0] rpc);
        exp_t e;
        logic [31:0] inst;
        stall = s; redirect = r; redirect_pc = rpc;
        inst = inst_at(m_pc, halt_addr);
        if (r) begin
            m_pc = {rpc[31:2], 2'b00};
            m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_inst = NOP; m_valid = 1'b0;
            m_halt = 1'b0;
            m_flcnt = m_flcnt + 32'd1;
        end else if (!m_halt && !s) begin
            if (inst == 32'h0) begin
                m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_inst = NOP; m_valid = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_inst = inst; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_fcnt = m_fcnt + 32'd1;
            end
        end
        e = '{pc: m_pc, ifpc: m_ifpc, ifpc4: m_ifpc4, inst: m_inst, valid: m_valid,
              halted: m_halt, fcnt: PERF ? m_fcnt : 32'h0, flcnt: PERF ? m_flcnt : 32'h0};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("imem_addr", imem_addr, e.pc);
        check("ifid_pc",   ifid_pc, e.ifpc);
        check("ifid_pc4",  ifid_pc4, e.ifpc4);
        check("ifid_inst", ifid_inst, e.inst);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        check("halted",    {31'b0, halted}, {31'b0, e.halted});
        check("fetch_cnt", fetch_cnt, e.fcnt);
        check("flush_cnt", flush_cnt, e.flcnt);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        halt_addr = 32'h1;
        model_reset();
        #2;
        check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First edge: the wrap instance fetches 0xFFFFFFFC and its PC wraps.
        cycle(1'b0, 1'b0, 32'h0);
        check("wrap_ifpc",  ifid_pc2, 32'hFFFF_FFFC);
        check("wrap_ifpc4", ifid_pc42, 32'h0);
        check("wrap_addr",  imem_addr2, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("boot_inst", ifid_inst, 32'h0000_0B93);

        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_000E);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);

        halt_addr = 32'h54;
        cycle(1'b0, 1'b1, 32'h54);
        cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h1C);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        cycle(1'b0, 1'b1, 32'h54);
        cycle(1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1 check_reset("async");
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction injected into IF/ID on flush or bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall_i  input  1  hazard-unit stall; hold PC and IF/ID.
REQ-006 redirect_i  input  1  taken branch/jump resolved in EX.
REQ-007 redirect_pc_i  input  32  branch/jump target.
REQ-008 imem_addr_o  output  32  byte address to instruction memory (combinational read).
REQ-009 imem_inst_i  input  32  little-endian assembled word returned for imem_addr_o, same cycle.
REQ-010 ifid_pc_o  output  32  PC of instruction held in IF/ID.
REQ-011 ifid_pc4_o  output  32  ifid_pc_o + 4.
REQ-012 ifid_inst_o  output  32  instruction held in IF/ID.
REQ-013 ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-014 halted_o  output  1  fetch is in HALT state.
REQ-015 fetch_cnt_o  output  32  fetched-instruction counter (see Configuration).
REQ-016 flush_cnt_o  output  32  redirect/flush counter (see Configuration).

Function
REQ-017 imem_addr_o SHALL equal the PC register combinationally.
REQ-018 State machine RUN/HALT; reset state RUN.
REQ-019 RUN, no redirect, no stall: PC <= PC+4; IF/ID <= {PC, PC+4, imem_inst_i, valid=1}.
REQ-020 RUN, stall_i=1, redirect_i=0: PC and all IF/ID outputs SHALL hold unchanged.
REQ-021 redirect_i=1 (any state, regardless of stall_i): PC <= {redirect_pc_i[31:2],2'b00}; IF/ID <= {0,0,NOP_INST,valid=0}; state <= RUN; one-cycle bubble.
REQ-022 RUN, no stall/redirect, imem_inst_i == 32'h0000_0000: IF/ID loaded with NOP_INST, valid=0; PC holds; state <= HALT.
REQ-023 HALT: PC holds, IF/ID holds NOP_INST with valid=0, stall_i ignored; exit only via redirect_i or rst.
REQ-024 halted_o SHALL be 1 exactly when state is HALT.
REQ-025 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000; ifid_pc4_o wraps identically.
REQ-026 Fetch-to-IF/ID latency: one cycle; redirect-to-first-valid-target-in-IF/ID: two cycles.

Reset
REQ-027 rst asserted: PC = RESET_PC, ifid_pc_o = 0, ifid_pc4_o = 0, ifid_inst_o = NOP_INST, ifid_valid_o = 0, state RUN, halted_o = 0, counters 0, immediately without clock.
REQ-028 rst mid-stall, mid-redirect or in HALT SHALL override all other inputs; first fetch from RESET_PC on first rising edge after deassertion.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: fetch_cnt_o increments on each REQ-019 capture; flush_cnt_o increments on each cycle with redirect_i=1; both wrap at 2^32.
REQ-030 Macro undefined: counters not instantiated; fetch_cnt_o and flush_cnt_o tied to 0; ports remain present.

Structure
REQ-031 Shared package riscv_pkg SHALL hold NOP_INST value, XLEN=32, INST_HALT=32'h0, and fetch_state_t enum {RUN, HALT}.
REQ-032 IF/ID pipeline register SHALL be a sub-module ifid_reg (load, flush, hold controls); PC logic and FSM in fetch_stage.

Verification
REQ-033 Reset, imem returns 32'h00000B13 at 0x0, 32'h00000B93 at 0x4: after 2 edges ifid_pc_o=0x4, ifid_inst_o=32'h00000B93, valid=1, imem_addr_o=0x8.
REQ-034 stall_i=1 for 3 cycles at PC 0x10: imem_addr_o stays 0x10, IF/ID unchanged, fetch_cnt_o unchanged.
REQ-035 stall_i=1 and redirect_i=1, redirect_pc_i=0x0E: next cycle PC=0x0C, ifid_inst_o=NOP_INST, valid=0, flush_cnt_o+1 (macro on).
REQ-036 imem returns 0 at 0x54: next cycle halted_o=1, PC=0x54, valid=0; 5 idle cycles no change; redirect to 0x1C -> halted_o=0, PC=0x1C.
REQ-037 RESET_PC=32'hFFFF_FFFC: after first edge ifid_pc_o=0xFFFFFFFC, ifid_pc4_o=0, imem_addr_o=0.
REQ-038 rst pulsed asynchronously mid-cycle while in HALT: outputs return to REQ-027 values before next edge; macro off: counters read 0 throughout.
